// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the counter-word encoder and checker.
// Both ends import this package so parity equations agree bit-for-bit.
package hamming_pkg;

    // What a block syndrome says about the received block.
    typedef enum logic [1:0] {
        SYN_NONE,
        SYN_DATA,
        SYN_PARITY
    } syn_class_e;

    // Syndrome codes {s2,s1,s0} for each single-bit error position.
    localparam logic [2:0] SYN_OK = 3'b000;
    localparam logic [2:0] SYN_D0 = 3'b111;
    localparam logic [2:0] SYN_D1 = 3'b011;
    localparam logic [2:0] SYN_D2 = 3'b101;
    localparam logic [2:0] SYN_D3 = 3'b110;
    localparam logic [2:0] SYN_P0 = 3'b001;
    localparam logic [2:0] SYN_P1 = 3'b010;
    localparam logic [2:0] SYN_P2 = 3'b100;

    // Parity of one 4-bit data block, returned as p[2:0].
    function automatic logic [2:0] enc_block(input logic [3:0] d);
        enc_block = {d[0] ^ d[2] ^ d[3],
                     d[0] ^ d[1] ^ d[3],
                     d[0] ^ d[1] ^ d[2]};
    endfunction

endpackage

// File: rtl/hamming74_block_fix.sv
// Combinational single-error corrector for one Hamming(7,4) block.
// Flips the bit named by the syndrome and classifies the error.
module hamming74_block_fix
    import hamming_pkg::*;
(
    input  logic [3:0]  d_i,
    input  logic [2:0]  p_i,
    input  logic [2:0]  syn_i,
    output logic [3:0]  d_o,
    output logic [2:0]  p_o,
    output syn_class_e  cls_o
);

    // Decode the syndrome into a single bit flip plus its error class.
    always_comb begin
        d_o   = d_i;
        p_o   = p_i;
        cls_o = SYN_DATA;
        case (syn_i)
            SYN_OK: cls_o = SYN_NONE;
            SYN_D0: d_o[0] = ~d_i[0];
            SYN_D1: d_o[1] = ~d_i[1];
            SYN_D2: d_o[2] = ~d_i[2];
            SYN_D3: d_o[3] = ~d_i[3];
            SYN_P0: begin
                p_o[0] = ~p_i[0];
                cls_o  = SYN_PARITY;
            end
            SYN_P1: begin
                p_o[1] = ~p_i[1];
                cls_o  = SYN_PARITY;
            end
            SYN_P2: begin
                p_o[2] = ~p_i[2];
                cls_o  = SYN_PARITY;
            end
            default: cls_o = SYN_NONE;
        endcase
    end

endmodule

// File: rtl/hamming_word_checker.sv
// Receive-side Hamming(7,4) word checker: two-stage valid/ready pipeline that
// corrects single-bit errors per block and keeps saturating error counters.
module hamming_word_checker
    import hamming_pkg::*;
#(
    parameter int width       = 4,
    parameter int blocks      = width / 4,
    parameter int parity_bits = blocks * 3,
    parameter int cnt_width   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width-1:0]       in_data,
    input  logic [parity_bits-1:0] in_parity,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [width-1:0]       out_data,
    output logic [parity_bits-1:0] out_parity,
    output logic [blocks-1:0]      out_err_blk,
    output logic [cnt_width-1:0]   data_err_count,
    output logic [cnt_width-1:0]   parity_err_count,
    input  logic                   cnt_clear
);

    localparam logic [cnt_width:0] ONE = 1;

    // One extra bit of headroom makes overflow visible before clamping.
    function automatic logic [cnt_width-1:0] sat_add(input logic [cnt_width-1:0] a,
                                                      input logic [cnt_width:0]   n);
        logic [cnt_width:0] s;
        s = {1'b0, a} + n;
        if (s[cnt_width]) sat_add = '1;
        else              sat_add = s[cnt_width-1:0];
    endfunction

    logic                   s1_valid_q;
    logic [width-1:0]       s1_data_q;
    logic [parity_bits-1:0] s1_parity_q;
    logic [blocks-1:0][2:0] s1_syn_q;
    logic [blocks-1:0][2:0] in_syn;

    logic                   s2_valid_q;
    logic [width-1:0]       s2_data_q;
    logic [parity_bits-1:0] s2_parity_q;
    logic [blocks-1:0]      s2_err_q;

    logic [width-1:0]       fix_data;
    logic [parity_bits-1:0] fix_parity;
    logic [blocks-1:0]      fix_err;
    syn_class_e             fix_cls [blocks];

    logic [cnt_width:0]     n_data;
    logic [cnt_width:0]     n_par;
    logic [cnt_width-1:0]   data_cnt_q, data_cnt_d;
    logic [cnt_width-1:0]   par_cnt_q,  par_cnt_d;

    logic s2_load;
    logic s1_adv;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_load;
    assign in_ready = !s1_valid_q || s2_load;

    // Syndrome of each incoming block: received parity vs recomputed parity.
    always_comb begin
        in_syn = '0;
        for (int b = 0; b < blocks; b++) begin
            in_syn[b] = in_parity[3*b +: 3] ^ enc_block(in_data[4*b +: 4]);
        end
    end

    // Stage 1: capture the accepted word together with its syndromes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
        if (in_valid && in_ready) begin
            s1_data_q   <= in_data;
            s1_parity_q <= in_parity;
            s1_syn_q    <= in_syn;
        end
    end

    for (genvar g = 0; g < blocks; g++) begin : g_fix
        hamming74_block_fix u_fix (
            .d_i   (s1_data_q[4*g +: 4]),
            .p_i   (s1_parity_q[3*g +: 3]),
            .syn_i (s1_syn_q[g]),
            .d_o   (fix_data[4*g +: 4]),
            .p_o   (fix_parity[3*g +: 3]),
            .cls_o (fix_cls[g])
        );
        assign fix_err[g] = |s1_syn_q[g];
    end

    // Count data-bit and parity-bit corrections in the word leaving stage 1.
    always_comb begin
        n_data = '0;
        n_par  = '0;
        for (int b = 0; b < blocks; b++) begin
            if (fix_cls[b] == SYN_DATA)   n_data = n_data + ONE;
            if (fix_cls[b] == SYN_PARITY) n_par  = n_par + ONE;
        end
        data_cnt_d = sat_add(data_cnt_q, n_data);
        par_cnt_d  = sat_add(par_cnt_q, n_par);
    end

    // Stage 2: hold the corrected word until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_parity_q <= '0;
            s2_err_q    <= '0;
        end else begin
            if (s2_load) s2_valid_q <= s1_valid_q;
            if (s1_adv) begin
                s2_data_q   <= fix_data;
                s2_parity_q <= fix_parity;
                s2_err_q    <= fix_err;
            end
        end
    end

    // Error counters; a clear wins over that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            data_cnt_q <= '0;
            par_cnt_q  <= '0;
        end else if (s1_adv) begin
            data_cnt_q <= data_cnt_d;
            par_cnt_q  <= par_cnt_d;
        end
    end

    assign out_valid        = s2_valid_q;
    assign out_data         = s2_data_q;
    assign out_parity       = s2_parity_q;
    assign out_err_blk      = s2_err_q;
    assign data_err_count   = data_cnt_q;
    assign parity_err_count = par_cnt_q;

endmodule

// File: tb/tb_hamming_word_checker.sv
// Self-checking bench for hamming_word_checker (width=8, two blocks).
// Reference corrects each block by nearest-codeword search over all 16 data values.
module tb_hamming_word_checker;

    localparam int W  = 8;
    localparam int NB = 2;
    localparam int PB = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [PB-1:0] in_parity;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [PB-1:0] out_parity;
    logic [NB-1:0] out_err_blk;
    logic [CW-1:0] data_err_count;
    logic [CW-1:0] parity_err_count;
    logic          cnt_clear;

    hamming_word_checker #(.width(W), .cnt_width(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_parity        (in_parity),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_parity       (out_parity),
        .out_err_blk      (out_err_blk),
        .data_err_count   (data_err_count),
        .parity_err_count (parity_err_count),
        .cnt_clear        (cnt_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_d_q [$];
    logic [PB-1:0] exp_p_q [$];
    logic [NB-1:0] exp_e_q [$];
    int            m_data = 0;
    int            m_par  = 0;

    logic [W-1:0]  last_d;
    logic [PB-1:0] last_p;
    logic [NB-1:0] last_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_enc(input logic [3:0] d);
        logic [2:0] p;
        p[2] = d[0] ^ d[2] ^ d[3];
        p[1] = d[0] ^ d[1] ^ d[3];
        p[0] = d[0] ^ d[1] ^ d[2];
        return p;
    endfunction

    // Nearest codeword (distance <= 1 always exists for Hamming(7,4)).
    task automatic model_push(input logic [W-1:0] d, input logic [PB-1:0] p);
        logic [W-1:0]  cd;
        logic [PB-1:0] cp;
        logic [NB-1:0] e;
        logic [6:0]    rx;
        logic [6:0]    cw;
        logic [3:0]    vv;
        int            nd;
        int            np;
        cd = '0; cp = '0; e = '0; nd = 0; np = 0;
        for (int b = 0; b < NB; b++) begin
            rx = {d[4*b +: 4], p[3*b +: 3]};
            for (int v = 0; v < 16; v++) begin
                vv = v[3:0];
                cw = {vv, ref_enc(vv)};
                if ($countones(rx ^ cw) <= 1) begin
                    cd[4*b +: 4] = vv;
                    cp[3*b +: 3] = cw[2:0];
                    e[b] = (rx != cw);
                    if (rx[6:3] != vv) nd++;
                    else if (rx != cw) np++;
                end
            end
        end
        m_data = (m_data + nd > 65535) ? 65535 : m_data + nd;
        m_par  = (m_par + np > 65535) ? 65535 : m_par + np;
        exp_d_q.push_back(cd);
        exp_p_q.push_back(cp);
        exp_e_q.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [PB-1:0] p);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_parity = p;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                $display("FAIL send_timeout: got in_ready %0h expected 1", in_ready);
                $fatal(1, "in_ready stuck low");
            end
        end
        model_push(d, p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_d_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", exp_d_q.size(), 0);
    endtask

    task automatic gen_word(output logic [W-1:0] d, output logic [PB-1:0] p, input int mode);
        int r;
        int k;
        d = W'($urandom);
        p = {ref_enc(d[7:4]), ref_enc(d[3:0])};
        for (int b = 0; b < NB; b++) begin
            r = (mode == 1) ? 5 : $urandom_range(0, 9);
            if (r >= 4) begin
                k = (mode == 1) ? $urandom_range(3, 6) : $urandom_range(0, 6);
                if (k >= 3) d[4*b + k - 3] = ~d[4*b + k - 3];
                else        p[3*b + k]     = ~p[3*b + k];
            end
            if (r == 9) begin
                k = $urandom_range(0, 6);
                if (k >= 3) d[4*b + k - 3] = ~d[4*b + k - 3];
                else        p[3*b + k]     = ~p[3*b + k];
            end
        end
    endtask

    // Output monitor: in-order scoreboard plus hold-while-stalled checks.
    logic          prev_hold = 1'b0;
    logic [W-1:0]  prev_d;
    logic [PB-1:0] prev_p;
    logic [NB-1:0] prev_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_parity", out_parity, prev_p);
                check("hold_err", out_err_blk, prev_e);
            end
            if (out_valid && out_ready) begin
                if (exp_d_q.size() == 0) begin
                    check("unexpected_out", out_data, 32'hDEAD);
                end else begin
                    check("out_data", out_data, exp_d_q.pop_front());
                    check("out_parity", out_parity, exp_p_q.pop_front());
                    check("out_err_blk", out_err_blk, exp_e_q.pop_front());
                    last_d = out_data;
                    last_p = out_parity;
                    last_e = out_err_blk;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_p    = out_parity;
            prev_e    = out_err_blk;
        end
    end

    logic [W-1:0]  wd;
    logic [PB-1:0] wp;
    logic          done;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = '0;
        out_ready = 1'b0; cnt_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_parity", out_parity, 0);
        check("rst_err_blk", out_err_blk, 0);
        check("rst_data_cnt", data_err_count, 0);
        check("rst_par_cnt", parity_err_count, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Clean word, plus two-register latency.
        send(8'h0B, 6'b000_010);
        check("lat_s1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_s2", out_valid, 1);
        drain();
        check("clean_data", last_d, 8'h0B);
        check("clean_err", last_e, 2'b00);
        check("clean_dcnt", data_err_count, 0);
        check("clean_pcnt", parity_err_count, 0);

        // d2 of block 0 flipped.
        send(8'h0F, 6'b000_010);
        drain();
        check("d2_data", last_d, 8'h0B);
        check("d2_err", last_e, 2'b01);
        check("d2_dcnt", data_err_count, 1);

        // p2 of block 0 flipped.
        send(8'h0B, 6'b000_110);
        drain();
        check("p2_data", last_d, 8'h0B);
        check("p2_parity", last_p, 6'b000_010);
        check("p2_dcnt", data_err_count, 1);
        check("p2_pcnt", parity_err_count, 1);

        // Bit 4 (d0 of block 1) flipped.
        send(8'hA0, 6'b010_000);
        drain();
        check("b4_data", last_d, 8'hB0);
        check("b4_err", last_e, 2'b10);
        check("b4_dcnt", data_err_count, 2);

        // Clear while idle.
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        m_data = 0; m_par = 0;
        check("clr_dcnt", data_err_count, 0);
        check("clr_pcnt", parity_err_count, 0);

        // Clear on the same edge the erroneous word advances to stage 2.
        send(8'h0F, 6'b000_110);
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        m_data = 0; m_par = 0;
        drain();
        check("clrpri_dcnt", data_err_count, 0);
        check("clrpri_pcnt", parity_err_count, 0);

        // Backpressure: four words against a stalled output for three cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    gen_word(wd, wp, 0);
                    send(wd, wp);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_front", out_data, exp_d_q[0]);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_dcnt", data_err_count, m_data);
        check("bp_pcnt", parity_err_count, m_par);

        // Random traffic with random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    gen_word(wd, wp, 0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(wd, wp);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = $urandom_range(0, 1) != 0;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rnd_dcnt", data_err_count, m_data);
        check("rnd_pcnt", parity_err_count, m_par);

        // Saturation: two data errors per word drive the count past all-ones.
        for (int i = 0; i < 32768; i++) begin
            gen_word(wd, wp, 1);
            send(wd, wp);
        end
        drain();
        check("sat_dcnt", data_err_count, 16'hFFFF);
        check("sat_pcnt", parity_err_count, m_par);
        gen_word(wd, wp, 1);
        send(wd, wp);
        drain();
        check("sat_hold", data_err_count, 16'hFFFF);

        // Reset with both stages full.
        out_ready = 1'b0;
        gen_word(wd, wp, 1);
        send(wd, wp);
        gen_word(wd, wp, 1);
        send(wd, wp);
        check("full_out_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_d_q.delete(); exp_p_q.delete(); exp_e_q.delete();
        m_data = 0; m_par = 0;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_data", out_data, 0);
        check("mrst_dcnt", data_err_count, 0);
        check("mrst_pcnt", parity_err_count, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mrst_no_replay", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
